// File: rtl/quad_enc_emulator_pkg.sv
// Shared definitions for the quadrature encoder emulator: FSM states and
// the forward Gray phase table.
package quad_enc_emulator_pkg;

   typedef enum logic [1:0] {
      ENC_IDLE = 2'd0,
      ENC_RUN  = 2'd1,
      ENC_DONE = 2'd2
   } enc_state_t;

   // Forward order of (A,B): 00 -> 10 -> 11 -> 01 -> 00
   function automatic logic [1:0] gray_ab(input logic [1:0] phase);
      logic [1:0] ab;
      case (phase)
         2'd0:    ab = 2'b00;
         2'd1:    ab = 2'b10;
         2'd2:    ab = 2'b11;
         default: ab = 2'b01;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/quad_enc_emulator_phase_step.sv
// Phase and index tracker: on each step strobe advances the Gray phase and
// the once-per-revolution index counter, with registered A/B/I outputs.
module quad_phase_step
   import quad_enc_emulator_pkg::*;
#(
   parameter int unsigned CPR = 4000
) (
   input  logic clk,
   input  logic reset,
   input  logic step,
   input  logic dir,
   output logic enc_a,
   output logic enc_b,
   output logic enc_i
);

   localparam int unsigned IDX_W = (CPR > 2) ? $clog2(CPR) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

   logic [1:0]       phase;
   logic [1:0]       phase_nxt;
   logic [IDX_W-1:0] idx_cnt;
   logic [IDX_W-1:0] idx_nxt;
   logic [1:0]       ab_nxt;

   always_comb begin
      phase_nxt = phase;
      idx_nxt   = idx_cnt;
      if (dir) begin
         phase_nxt = phase + 2'd1;
         idx_nxt   = (idx_cnt == IDX_MAX) ? '0 : idx_cnt + IDX_W'(1);
      end else begin
         phase_nxt = phase - 2'd1;
         idx_nxt   = (idx_cnt == '0) ? IDX_MAX : idx_cnt - IDX_W'(1);
      end
      ab_nxt = gray_ab(phase_nxt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase   <= '0;
         idx_cnt <= '0;
         enc_a   <= 1'b0;
         enc_b   <= 1'b0;
         enc_i   <= 1'b1;
      end else if (step) begin
         phase   <= phase_nxt;
         idx_cnt <= idx_nxt;
         enc_a   <= ab_nxt[1];
         enc_b   <= ab_nxt[0];
         enc_i   <= (idx_nxt == '0);
      end
   end

endmodule

// File: rtl/quad_enc_emulator.sv
// Quadrature encoder emulator: accepts move commands over valid/ready and
// emits Gray-coded A/B edges at a programmable spacing, tracking position.
module quad_enc_emulator
   import quad_enc_emulator_pkg::*;
#(
   parameter int unsigned POS_W = 32,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned DIV_W = 16,
   parameter int unsigned CPR   = 4000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [DIV_W-1:0]        div,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_dir,
   input  logic [CNT_W-1:0]        cmd_count,
   output logic                    enc_a,
   output logic                    enc_b,
   output logic                    enc_i,
   output logic signed [POS_W-1:0] position,
   output logic                    busy,
   output logic                    done
);

   enc_state_t       state;
   logic [DIV_W-1:0] timer;
   logic [DIV_W-1:0] reload;
   logic [DIV_W-1:0] div_m1;
   logic [CNT_W-1:0] remaining;
   logic             dir_q;
   logic             step;

   assign cmd_ready = (state == ENC_IDLE) & enable & ~reset;

   always_comb begin
      div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
      step   = (state == ENC_RUN) & enable & (timer == '0) & (remaining != '0);
   end

   // RUN lingers one cycle after the last edge so done trails that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ENC_IDLE;
         timer     <= '0;
         reload    <= '0;
         remaining <= '0;
         dir_q     <= 1'b0;
         position  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ENC_IDLE: begin
               done <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  dir_q     <= cmd_dir;
                  reload    <= div_m1;
                  timer     <= div_m1;
                  remaining <= cmd_count;
                  busy      <= 1'b1;
                  if (cmd_count == '0) begin
                     state <= ENC_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ENC_RUN;
                  end
               end
            end
            ENC_RUN: begin
               if (enable) begin
                  if (remaining == '0) begin
                     state <= ENC_DONE;
                     done  <= 1'b1;
                  end else if (timer == '0) begin
                     remaining <= remaining - CNT_W'(1);
                     timer     <= reload;
                     position  <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
                  end else begin
                     timer <= timer - DIV_W'(1);
                  end
               end
            end
            ENC_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ENC_IDLE;
            end
            default: begin
               state <= ENC_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   quad_phase_step #(
      .CPR(CPR)
   ) u_phase (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .dir   (dir_q),
      .enc_a (enc_a),
      .enc_b (enc_b),
      .enc_i (enc_i)
   );

endmodule

// File: doc/quad_enc_emulator.md
Name: quad_enc_emulator

Overview:
- Drives the ENC_A/ENC_B pins of the rapcore quadrature decoder input, plus an index pulse.
- Used in Caravel testbenches and as an on-chip loopback source.
- Accepts move commands (direction + edge count) over a valid/ready handshake.
- Emits Gray-coded A/B edges at a programmable minimum spacing, tracks the emitted position and generates a once-per-revolution index.

Parameters:
- POS_W, 32, width of the signed position counter.
- CNT_W, 16, width of the command edge count.
- DIV_W, 16, width of the edge-spacing divider.
- CPR, 4000, quadrature counts per revolution, used for index generation (must be >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, the move pauses: timer and outputs hold, cmd_ready is low.
- div  in  DIV_W  clocks between successive edges; 0 is treated as 1.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  1  1 = forward (A leads B, position increments), 0 = reverse.
- cmd_count  in  CNT_W  number of quadrature edges to emit.
- enc_a  out  1  quadrature channel A.
- enc_b  out  1  quadrature channel B.
- enc_i  out  1  index, high while idx_cnt == 0.
- position  out  POS_W  signed count of emitted edges, two's complement.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at end of each accepted command.

Behaviour:
- One clock domain, synchronous active-high reset.
- Reset values: enc_a = 0, enc_b = 0, position = 0, idx_cnt = 0 (so enc_i = 1), busy = 0, done = 0, state = IDLE. cmd_ready = 1 if enable is high.
- cmd_ready = (state == IDLE) & enable & ~reset. It is combinational from state and enable only, never from cmd_valid.
- Handshake: a command is accepted on a rising clk edge where cmd_valid & cmd_ready. cmd_dir, cmd_count and div are latched on acceptance. Later changes to div do not affect the move in flight.
- States:
  - IDLE: on accept with count == 0, go to DONE with no edges. On accept with count > 0, load timer = max(div,1) - 1, remaining = count, go to RUN.
  - RUN: when enable is high, the timer decrements each cycle. At timer == 0: emit one edge, remaining--, reload the timer. After the final edge (remaining becomes 0), go to DONE. When enable is low, everything holds.
  - DONE: done = 1 for exactly this cycle, then go to IDLE.
- busy = 1 in RUN and DONE.
- Edge timing: with D = max(div,1), edge k (k = 1..N) appears on the outputs D*k cycles after the accept edge, assuming no pause. done is high in the cycle after edge N. The earliest next accept is the cycle after done.
- Edge sequence (A,B):
  - forward: 00 -> 10 -> 11 -> 01 -> 00.
  - reverse: the exact inverse.
  - Exactly one of A/B toggles per edge. The phase persists across commands and is never reset except by reset.
- Position updates in the same cycle as the edge: +1 forward, -1 reverse. It wraps modulo 2^POS_W (0x7FFFFFFF + 1 -> 0x80000000).
- idx_cnt range 0..CPR-1:
  - forward: increments, CPR-1 -> 0.
  - reverse: decrements, 0 -> CPR-1.
- enc_i is registered and equals (idx_cnt == 0) after the update.
- Simultaneous events: cmd_valid while busy is ignored (cmd_ready low). enable dropping in the same cycle the timer hits 0 suppresses that edge; it fires on the first enabled cycle instead.
- reset mid-move: the move is abandoned, all state returns to reset values, and no done pulse is issued.

Decomposition:
- Shared package/defines (rapcore_caravel_defines style):
  - state encodings: ENC_IDLE = 2'd0, ENC_RUN = 2'd1, ENC_DONE = 2'd2.
  - forward Gray phase table.
- One natural sub-module: quad_phase_step. It holds the 2-bit phase register plus idx_cnt. On a step strobe with dir it advances the phase and index, and it outputs enc_a, enc_b and enc_i.
- The top module holds the handshake, FSM, divider timer, remaining counter and position.

Test Plan:
- Reset: assert reset 3 cycles, release -> enc_a = enc_b = 0, enc_i = 1, position = 0, busy = 0, cmd_ready = 1.
- Forward 4 edges, div = 3: (A,B) = 10, 11, 01, 00 at +3, +6, +9, +12 cycles after accept; position = 4; done pulses once at +13; cmd_ready high at +14.
- Reverse 6 edges from position 4, div = 0: one edge per cycle, (A,B) = 01, 11, 10, 00, 01, 11; position = -2; with CPR = 8, idx_cnt passes 4, 3, 2, 1, 0, 7, 6 and enc_i is high exactly while idx_cnt = 0.
- count = 0 command: no A/B change, position unchanged, done pulses the cycle after accept; a cmd_valid held high during busy is not accepted.
- Pause: forward 3 edges, div = 2; drop enable for 5 cycles after edge 1 -> edges 2 and 3 are delayed by exactly 5 cycles; final position = +3.
- Reset mid-move: forward 100 edges, div = 1; assert reset after edge 10 -> outputs return to reset values and no done pulse; a new command is accepted normally afterwards.
